handshake_arbiter: RTL and testbench

HANDSHAKE_ARBITER -- requirements
Module: handshake_arbiter

---
 rtl/handshake_arb_pkg.sv | 26 ++
 rtl/handshake_arbiter_rr_select.sv | 29 ++
 rtl/handshake_arbiter.sv | 127 ++++++++++++
 tb/tb_handshake_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/handshake_arb_pkg.sv
// Shared types, defaults and helpers for the four-phase handshake arbiter.
package handshake_arb_pkg;

  localparam int unsigned N_DEF       = 4;
  localparam int unsigned TIMEOUT_DEF = 1000;
  localparam int unsigned CW_DEF      = 16;
  localparam int unsigned MAX_N       = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2,
    ST_REL  = 2'd3
  } state_t;

  // Index of the set bit in a one-hot vector of up to MAX_N requesters.
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_N-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < int'(MAX_N); i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/handshake_arbiter_rr_select.sv
// Combinational round-robin picker: search starts just after the last winner.
module rr_select
  import handshake_arb_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  winner,
  output logic          valid
);

  logic [LW-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = LW'((32'(last) + i) % N);
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/handshake_arbiter.sv
// N-way four-phase handshake arbiter in front of one shared downstream resource.
module handshake_arbiter
  import handshake_arb_pkg::*;
#(
  parameter int unsigned N       = N_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned CW      = CW_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_in,
  output logic [N-1:0] ack_out,
  output logic         req_out,
  input  logic         ack_in,
  output logic [N-1:0] grant,
  output logic         busy,
  output logic         timeout_err
);

  localparam int unsigned LW      = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] last_q, last_d;
  logic [LW-1:0] owner_q, owner_d;
  logic [N-1:0]  grant_d, ack_out_d;
  logic          req_out_d, busy_d, timeout_err_d;
  logic [N-1:0]  sel_winner;
  logic          sel_valid;

  rr_select #(.N(N), .LW(LW)) u_sel (
    .req    (req_in),
    .last   (last_q),
    .winner (sel_winner),
    .valid  (sel_valid)
  );

  // State and registered outputs; reset leaves index 0 as next-highest priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_q      <= LW'(N - 1);
      owner_q     <= '0;
      grant       <= '0;
      ack_out     <= '0;
      req_out     <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      grant       <= grant_d;
      ack_out     <= ack_out_d;
      req_out     <= req_out_d;
      busy        <= busy_d;
      timeout_err <= timeout_err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_d        = last_q;
    owner_d       = owner_q;
    grant_d       = grant;
    ack_out_d     = ack_out;
    req_out_d     = req_out;
    busy_d        = busy;
    timeout_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A stale ack_in from the resource blocks any new grant.
        if (sel_valid && !ack_in) begin
          state_d   = ST_REQ;
          grant_d   = sel_winner;
          owner_d   = LW'(onehot_to_idx(MAX_N'(sel_winner)));
          req_out_d = 1'b1;
          busy_d    = 1'b1;
          cnt_d     = '0;
        end
      end

      ST_REQ: begin
        // A real ack beats a timeout landing on the same edge.
        if (ack_in) begin
          state_d   = ST_ACK;
          req_out_d = 1'b0;
          ack_out_d = grant;
          cnt_d     = '0;
        end else if ((TIMEOUT > 0) && (cnt_q == TO_LAST)) begin
          state_d       = ST_ACK;
          req_out_d     = 1'b0;
          ack_out_d     = grant;
          timeout_err_d = 1'b1;
          cnt_d         = '0;
        end else if (TIMEOUT > 0) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_ACK: begin
        if (((req_in & grant) == '0) && !ack_in) begin
          state_d   = ST_REL;
          ack_out_d = '0;
          last_d    = owner_q;
        end
      end

      ST_REL: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_handshake_arbiter.sv
// Directed bench for handshake_arbiter: vector table plus multi-cycle corner sequences.
module tb_handshake_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_in = '0;
  logic       ack_in = 1'b0;
  logic [3:0] ack_out;
  logic       req_out;
  logic [3:0] grant;
  logic       busy;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  handshake_arbiter #(.N(4), .TIMEOUT(8), .CW(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_in      (req_in),
    .ack_out     (ack_out),
    .req_out     (req_out),
    .ack_in      (ack_in),
    .grant       (grant),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       ack;
    logic [3:0] g;
    logic       ro;
    logic [3:0] ao;
    logic       b;
    logic       te;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at negedge, sample just after the rising edge.
  task automatic cyc(input logic [3:0] r, input logic a, input logic rs);
    @(negedge clk);
    req_in = r;
    ack_in = a;
    rst    = rs;
    @(posedge clk);
    #1;
    chk("inv.ack_out_onehot0", 8'($onehot0(ack_out)), 8'd1);
    chk("inv.grant_onehot0", 8'($onehot0(grant)), 8'd1);
    chk("inv.req_out_implies_busy", 8'(!req_out || busy), 8'd1);
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic ro,
                            input logic [3:0] ao, input logic b, input logic te);
    chk({tag, ".grant"}, 8'(grant), 8'(g));
    chk({tag, ".req_out"}, 8'(req_out), 8'(ro));
    chk({tag, ".ack_out"}, 8'(ack_out), 8'(ao));
    chk({tag, ".busy"}, 8'(busy), 8'(b));
    chk({tag, ".timeout_err"}, 8'(timeout_err), 8'(te));
  endtask

  initial begin
    logic [3:0] fair_exp [5];
    int hi;
    int pulses;

    // rst req ack | grant req_out ack_out busy terr
    tbl[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 4'b0001, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 4'b0000, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 4'b0000, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 4'b0000, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 4'b0001, 1'b1, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 4'b0001, 1'b1, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 4'b0000, 1'b1, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 4'b0000, 1'b0, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};

    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].req, tbl[i].ack, tbl[i].rst);
      expect_out($sformatf("vec%0d", i), tbl[i].g, tbl[i].ro, tbl[i].ao, tbl[i].b, tbl[i].te);
    end

    // Fairness: all four requesting, each drops its request once acked.
    fair_exp[0] = 4'b0001;
    fair_exp[1] = 4'b0010;
    fair_exp[2] = 4'b0100;
    fair_exp[3] = 4'b1000;
    fair_exp[4] = 4'b0001;
    cyc(4'b0000, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      cyc(4'b1111, 1'b0, 1'b0);
      expect_out($sformatf("fair%0d.req", k), fair_exp[k], 1'b1, 4'b0000, 1'b1, 1'b0);
      cyc(4'b1111, 1'b1, 1'b0);
      expect_out($sformatf("fair%0d.ack", k), fair_exp[k], 1'b0, fair_exp[k], 1'b1, 1'b0);
      cyc(4'b1111 & ~fair_exp[k], 1'b0, 1'b0);
      expect_out($sformatf("fair%0d.rel", k), fair_exp[k], 1'b0, 4'b0000, 1'b1, 1'b0);
      cyc(4'b1111, 1'b0, 1'b0);
      expect_out($sformatf("fair%0d.idle", k), 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    end

    // Timeout: no ack from downstream, req_out must stay up exactly 8 cycles.
    cyc(4'b0000, 1'b0, 1'b1);
    cyc(4'b0100, 1'b0, 1'b0);
    expect_out("to.enter", 4'b0100, 1'b1, 4'b0000, 1'b1, 1'b0);
    hi = 1;
    pulses = 0;
    for (int k = 0; k < 20 && req_out; k++) begin
      cyc(4'b0100, 1'b0, 1'b0);
      if (req_out) hi++;
      if (timeout_err) pulses++;
    end
    chk("to.req_out_cycles", 8'(hi), 8'd8);
    expect_out("to.fire", 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1);
    cyc(4'b0100, 1'b0, 1'b0);
    if (timeout_err) pulses++;
    expect_out("to.hold", 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b0);
    chk("to.pulses", 8'(pulses), 8'd1);
    cyc(4'b0000, 1'b0, 1'b0);
    expect_out("to.rel", 4'b0100, 1'b0, 4'b0000, 1'b1, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    expect_out("to.idle", 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);

    // Race: ack arrives on the same edge the counter would time out.
    cyc(4'b0000, 1'b0, 1'b1);
    cyc(4'b0100, 1'b0, 1'b0);
    expect_out("race.enter", 4'b0100, 1'b1, 4'b0000, 1'b1, 1'b0);
    for (int k = 1; k < 8; k++) begin
      cyc(4'b0100, 1'b0, 1'b0);
      expect_out($sformatf("race.wait%0d", k), 4'b0100, 1'b1, 4'b0000, 1'b1, 1'b0);
    end
    cyc(4'b0100, 1'b1, 1'b0);
    expect_out("race.ack", 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    expect_out("race.rel", 4'b0100, 1'b0, 4'b0000, 1'b1, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    expect_out("race.idle", 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);

    // Owner drops request mid-REQ; another requester appears but must wait.
    cyc(4'b0000, 1'b0, 1'b1);
    cyc(4'b0001, 1'b0, 1'b0);
    expect_out("abort.enter", 4'b0001, 1'b1, 4'b0000, 1'b1, 1'b0);
    cyc(4'b1000, 1'b0, 1'b0);
    expect_out("abort.hold", 4'b0001, 1'b1, 4'b0000, 1'b1, 1'b0);
    cyc(4'b1000, 1'b1, 1'b0);
    expect_out("abort.ack", 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0);
    cyc(4'b1000, 1'b0, 1'b0);
    expect_out("abort.rel", 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0);
    cyc(4'b1000, 1'b0, 1'b0);
    expect_out("abort.idle", 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    cyc(4'b1000, 1'b0, 1'b0);
    expect_out("abort.next", 4'b1000, 1'b1, 4'b0000, 1'b1, 1'b0);

    // Reset while requester 1 is acked, with a stale ack_in held afterwards.
    cyc(4'b0000, 1'b0, 1'b1);
    cyc(4'b0010, 1'b0, 1'b0);
    expect_out("rst.enter", 4'b0010, 1'b1, 4'b0000, 1'b1, 1'b0);
    cyc(4'b0010, 1'b1, 1'b0);
    expect_out("rst.ack", 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b0);
    cyc(4'b0100, 1'b1, 1'b1);
    expect_out("rst.reset", 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    cyc(4'b0100, 1'b1, 1'b0);
    expect_out("rst.stale0", 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    cyc(4'b0100, 1'b1, 1'b0);
    expect_out("rst.stale1", 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    cyc(4'b0100, 1'b0, 1'b0);
    expect_out("rst.grant", 4'b0100, 1'b1, 4'b0000, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
